key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 30 +++
 rtl/key_debounce_if.sv | 29 ++
 rtl/key_debounce_chan.sv | 145 ++++++++++++++
 rtl/key_debounce.sv | 50 +++++
 tb/tb_key_debounce.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Channel FSM encoding plus the cycle counts for a 50 MHz clock.
package key_debounce_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StHeld,
    StRepeat,
    StDebRelease
  } chan_state_e;

  localparam int unsigned DefNKeys             = 3;
  localparam int unsigned DefDebounceCycles    = 1000000;
  localparam int unsigned DefRepeatDelayCycles = 25000000;
  localparam int unsigned DefRepeatRateCycles  = 5000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold every count from 0 up to and including max_cycles.
  function automatic int unsigned cnt_width(input int unsigned max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pin / PIO bundle between the KEY pins, the conditioner and its consumers.
// The slave side is the conditioner; the master side is the board/consumer side.
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 3
);

  logic [N_KEYS-1:0] key_n_i;
  logic [N_KEYS-1:0] key_export_o;
  logic [N_KEYS-1:0] key_press_o;
  logic [N_KEYS-1:0] key_release_o;
  logic [N_KEYS-1:0] key_repeat_o;

  modport master (
    output key_n_i,
    input  key_export_o,
    input  key_press_o,
    input  key_release_o,
    input  key_repeat_o
  );

  modport slave (
    input  key_n_i,
    output key_export_o,
    output key_press_o,
    output key_release_o,
    output key_repeat_o
  );

endinterface

// File: rtl/key_debounce_chan.sv
// One key: two-flop synchroniser, debounce/auto-repeat FSM and registered event pulses.
// Auto-repeat is only built when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY_CYCLES = DefRepeatDelayCycles,
  parameter int unsigned REPEAT_RATE_CYCLES  = DefRepeatRateCycles,
  parameter int unsigned CntW                = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $fatal(1, "key_debounce_chan: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY_CYCLES < 2) begin : g_bad_delay
    $fatal(1, "key_debounce_chan: REPEAT_DELAY_CYCLES must be >= 2");
  end
  if (REPEAT_RATE_CYCLES < 2) begin : g_bad_rate
    $fatal(1, "key_debounce_chan: REPEAT_RATE_CYCLES must be >= 2");
  end

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [CntW-1:0] DlyLast  = CntW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CntW-1:0] RateLast = CntW'(REPEAT_RATE_CYCLES - 1);
`endif

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  chan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            repeat_q, repeat_d;

  always_comb begin
    sync1_d   = key_n_i;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!sync2_q) state_d = StDebPress;
      end
      StDebPress: begin
        if (sync2_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeld;
          level_d = 1'b0;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StHeld: begin
        if (sync2_q) begin
          state_d = StDebRelease;
          cnt_d   = '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        end else if (cnt_q == DlyLast) begin
          state_d  = StRepeat;
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
`else
        end else begin
          // Nothing to time while held; park the counter.
          cnt_d = '0;
        end
`endif
      end
`ifdef KEY_DEBOUNCE_REPEAT_EN
      StRepeat: begin
        // Release wins over a coincident repeat terminal count.
        if (sync2_q) begin
          state_d = StDebRelease;
          cnt_d   = '0;
        end else if (cnt_q == RateLast) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
`endif
      StDebRelease: begin
        if (!sync2_q) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          level_d   = 1'b1;
          release_d = 1'b1;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce.sv
// DE1-SoC KEY conditioner: N_KEYS independent channels feeding the HPS key PIO and
// FPGA-side event consumers. Define KEY_DEBOUNCE_REPEAT_EN to build auto-repeat.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS              = DefNKeys,
  parameter int unsigned DEBOUNCE_CYCLES     = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY_CYCLES = DefRepeatDelayCycles,
  parameter int unsigned REPEAT_RATE_CYCLES  = DefRepeatRateCycles
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  key_debounce_if.slave       key_bus
);

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned CntW =
      cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
`else
  localparam int unsigned CntW = cnt_width(max3(DEBOUNCE_CYCLES, 0, 0));
`endif

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] release_p;
  logic [N_KEYS-1:0] repeat_p;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .CntW               (CntW)
    ) u_chan (
      .clk_i    (clk_clk),
      .rst_i    (reset_reset),
      .key_n_i  (key_bus.key_n_i[i]),
      .level_o  (level[i]),
      .press_o  (press[i]),
      .release_o(release_p[i]),
      .repeat_o (repeat_p[i])
    );
  end

  assign key_bus.key_export_o  = level;
  assign key_bus.key_press_o   = press;
  assign key_bus.key_release_o = release_p;
  assign key_bus.key_repeat_o  = repeat_p;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short cycle counts; expectations are edge
// numbers worked out by hand, with repeat expectations following KEY_DEBOUNCE_REPEAT_EN.
module tb_key_debounce;

  localparam int unsigned NKeys = 3;
  localparam int unsigned Deb   = 4;
  localparam int unsigned Dly   = 10;
  localparam int unsigned Rate  = 3;
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_debounce_if #(.N_KEYS(NKeys)) bus ();

  key_debounce #(
    .N_KEYS             (NKeys),
    .DEBOUNCE_CYCLES    (Deb),
    .REPEAT_DELAY_CYCLES(Dly),
    .REPEAT_RATE_CYCLES (Rate)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .key_bus    (bus)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int e, input logic [2:0] p,
                         input logic [2:0] r, input logic [2:0] rp, input logic [2:0] x);
    chk($sformatf("%s_press_e%0d", tag, e), 32'(bus.key_press_o), 32'(p));
    chk($sformatf("%s_release_e%0d", tag, e), 32'(bus.key_release_o), 32'(r));
    chk($sformatf("%s_repeat_e%0d", tag, e), 32'(bus.key_repeat_o), 32'(rp));
    chk($sformatf("%s_export_e%0d", tag, e), 32'(bus.key_export_o), 32'(x));
  endtask

  function automatic logic [2:0] sel(input bit c, input logic [2:0] m);
    return c ? m : 3'b000;
  endfunction

  initial begin
    rst         = 1'b1;
    bus.key_n_i = 3'b111;
    cyc();
    cyc();
    chk_all("reset", 0, 3'b000, 3'b000, 3'b000, 3'b111);
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      cyc();
      chk_all("idle", e, 3'b000, 3'b000, 3'b000, 3'b111);
    end

    // Clean press and release on key 0.
    for (int e = 0; e < 10; e++) begin
      bus.key_n_i = 3'b110;
      cyc();
      chk_all("s1p", e, sel(e == 6, 3'b001), 3'b000, 3'b000,
              (e >= 6) ? 3'b110 : 3'b111);
    end
    for (int e = 0; e < 10; e++) begin
      bus.key_n_i = 3'b111;
      cyc();
      chk_all("s1r", e, 3'b000, sel(e == 6, 3'b001), 3'b000,
              (e >= 6) ? 3'b111 : 3'b110);
    end

    // Bounce on key 1: 3-cycle glitch rejected, press 6 edges after the second low.
    for (int e = 0; e < 24; e++) begin
      bus.key_n_i = (e <= 2 || (e >= 4 && e <= 13)) ? 3'b101 : 3'b111;
      cyc();
      chk_all("s2", e, sel(e == 10, 3'b010), sel(e == 20, 3'b010), 3'b000,
              (e >= 10 && e < 20) ? 3'b101 : 3'b111);
    end

    // Auto-repeat on key 2; the terminal count at edge 25 coincides with release.
    for (int e = 0; e < 32; e++) begin
      bus.key_n_i = (e <= 22) ? 3'b011 : 3'b111;
      cyc();
      chk_all("s3", e, sel(e == 6, 3'b100), sel(e == 29, 3'b100),
              sel(RepEn && (e == 16 || e == 19 || e == 22), 3'b100),
              (e >= 6 && e < 29) ? 3'b011 : 3'b111);
    end

    // Release bounce on key 0, then reset while repeating, then re-press.
    for (int e = 0; e < 41; e++) begin
      bus.key_n_i = (e == 8 || e == 9) ? 3'b111 : 3'b110;
      rst         = (e == 30);
      cyc();
      if (e < 30) begin
        chk_all("s4", e, sel(e == 6, 3'b001), 3'b000,
                sel(RepEn && (e == 22 || e == 25 || e == 28), 3'b001),
                (e >= 6) ? 3'b110 : 3'b111);
      end else begin
        chk_all("s5", e, sel(e == 37, 3'b001), 3'b000, 3'b000,
                (e >= 37) ? 3'b110 : 3'b111);
      end
    end
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      bus.key_n_i = 3'b111;
      cyc();
      chk_all("s5r", e, 3'b000, sel(e == 6, 3'b001), 3'b000,
              (e >= 6) ? 3'b111 : 3'b110);
    end

    // All three keys pressed and released together.
    for (int e = 0; e < 10; e++) begin
      bus.key_n_i = 3'b000;
      cyc();
      chk_all("s6p", e, sel(e == 6, 3'b111), 3'b000, 3'b000,
              (e >= 6) ? 3'b000 : 3'b111);
    end
    for (int e = 0; e < 10; e++) begin
      bus.key_n_i = 3'b111;
      cyc();
      chk_all("s6r", e, 3'b000, sel(e == 6, 3'b111), 3'b000,
              (e >= 6) ? 3'b111 : 3'b000);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
